// File: rtl/me_lsu_if.sv
// me_lsu_if -- data-memory bus between the memory-stage LSU and the data memory.
// The LSU is the master: it raises dmem_req with address/data/strobes and holds
// them until dmem_gnt; load data comes back later with dmem_rvalid.
interface me_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/me_lsu.sv
// me_lsu -- memory-stage load/store unit.
// Decodes the load/store op, checks natural alignment, issues one request on a
// 64-bit data bus, extracts/extends the load lane and stalls the pipeline until
// the access completes. One transaction at a time; a DONE cycle separates
// consecutive accesses.
// Optional build macro: LSU_TIMEOUT_EN -- adds an 8-bit read-response timeout in
// WAIT_R that ends the load with mem_err after 256 cycles without dmem_rvalid.
module me_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  me_readMem,
    input  logic [2:0]  me_writeMem,
    input  logic [63:0] me_outAlu,
    input  logic [63:0] me_rs2Data,
    me_lsu_if.master    dmem,
    output logic        me_stall,
    output logic [63:0] wb_memOut,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Access size encoding: byte, half, word, double.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    state_t      state;

    // Decoded view of the incoming op.
    logic        load_present;
    logic        store_present;
    logic        op_present;
    logic [1:0]  op_size;
    logic        op_signed;
    logic        op_aligned;

    // Load attributes captured when the request is issued; the pipeline inputs
    // are not trusted again once the transaction is in flight.
    logic        ld_is_load;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [2:0]  ld_off;

`ifdef LSU_TIMEOUT_EN
    logic [7:0]  wait_cnt;
`endif

    // Natural alignment: the low log2(size) address bits must be zero.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = (off[0] == 1'b0);
            SZ_W:    is_aligned = (off[1:0] == 2'b00);
            default: is_aligned = (off == 3'b000);
        endcase
    endfunction

    // Byte strobes for a store of the given size placed at byte offset off.
    function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        store_strb = base << off;
    endfunction

    // Store data moved into its byte lanes; unused lanes are masked by strobes.
    function automatic logic [63:0] store_data(input logic [63:0] data, input logic [2:0] off);
        store_data = data << {off, 3'b000};
    endfunction

    // Bring the addressed lane down to bit 0 and sign- or zero-extend it.
    function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                                 input logic [1:0]  size,
                                                 input logic        sgn,
                                                 input logic [2:0]  off);
        logic [63:0] sh;
        logic        fill;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_B: begin
                fill         = sgn & sh[7];
                load_extract = {{56{fill}}, sh[7:0]};
            end
            SZ_H: begin
                fill         = sgn & sh[15];
                load_extract = {{48{fill}}, sh[15:0]};
            end
            SZ_W: begin
                fill         = sgn & sh[31];
                load_extract = {{32{fill}}, sh[31:0]};
            end
            default: begin
                fill         = 1'b0;
                load_extract = sh;
            end
        endcase
    endfunction

    // Decode the op: loads win over stores, store codes 101..111 mean no store.
    always_comb begin
        load_present  = (me_readMem != 3'b000);
        store_present = (me_writeMem >= 3'b001) && (me_writeMem <= 3'b100);
        op_present    = load_present | store_present;
        op_size       = SZ_B;
        op_signed     = 1'b0;
        if (load_present) begin
            case (me_readMem)
                3'b001:  begin op_size = SZ_B; op_signed = 1'b1; end
                3'b010:  begin op_size = SZ_H; op_signed = 1'b1; end
                3'b011:  begin op_size = SZ_W; op_signed = 1'b1; end
                3'b100:  begin op_size = SZ_D; op_signed = 1'b0; end
                3'b101:  begin op_size = SZ_B; op_signed = 1'b0; end
                3'b110:  begin op_size = SZ_H; op_signed = 1'b0; end
                default: begin op_size = SZ_W; op_signed = 1'b0; end
            endcase
        end else if (store_present) begin
            case (me_writeMem)
                3'b001:  op_size = SZ_B;
                3'b010:  op_size = SZ_H;
                3'b011:  op_size = SZ_W;
                default: op_size = SZ_D;
            endcase
        end
        op_aligned = is_aligned(op_size, me_outAlu[2:0]);
    end

    // Stall upstream while an op waits in IDLE or is in flight; DONE releases it.
    always_comb begin
        case (state)
            IDLE:    me_stall = op_present;
            REQ:     me_stall = 1'b1;
            WAIT_R:  me_stall = 1'b1;
            default: me_stall = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus outputs, load result and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 64'd0;
            dmem.dmem_wdata <= 64'd0;
            dmem.dmem_wstrb <= 8'd0;
            wb_memOut       <= 64'd0;
            mem_err         <= 1'b0;
            ld_is_load      <= 1'b0;
            ld_size         <= SZ_B;
            ld_signed       <= 1'b0;
            ld_off          <= 3'd0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt        <= 8'd0;
`endif
        end else begin
            // mem_err is a single-cycle pulse; it is only raised on entry to DONE.
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_present) begin
                        ld_is_load <= load_present;
                        ld_size    <= op_size;
                        ld_signed  <= op_signed;
                        ld_off     <= me_outAlu[2:0];
                        if (op_aligned) begin
                            state           <= REQ;
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= ~load_present;
                            dmem.dmem_addr  <= {me_outAlu[63:3], 3'b000};
                            dmem.dmem_wdata <= load_present ? 64'd0
                                                            : store_data(me_rs2Data, me_outAlu[2:0]);
                            dmem.dmem_wstrb <= load_present ? 8'd0
                                                            : store_strb(op_size, me_outAlu[2:0]);
                        end else begin
                            // Misaligned: never touches the bus, reports through DONE.
                            state     <= DONE;
                            mem_err   <= 1'b1;
                            wb_memOut <= 64'd0;
                        end
                    end
                end
                REQ: begin
                    // Request fields stay untouched until the grant arrives.
                    if (dmem.dmem_gnt) begin
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        state         <= ld_is_load ? WAIT_R : DONE;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt      <= 8'd0;
`endif
                    end
                end
                WAIT_R: begin
                    if (dmem.dmem_rvalid) begin
                        wb_memOut <= load_extract(dmem.dmem_rdata, ld_size, ld_signed, ld_off);
                        state     <= DONE;
`ifdef LSU_TIMEOUT_EN
                    end else if (wait_cnt == 8'hFF) begin
                        // Response never came: give up with a zero result.
                        wb_memOut <= 64'd0;
                        mem_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    // DONE: the pipeline advances this cycle; inputs are ignored.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
